// File: rtl/zapper_flash_sequencer_if.sv
// Pin-side bundle between the zapper I/O, the pattern generator and the flash sequencer.
// The sequencer takes the slave view; whatever drives the pins and watches the verdict takes the master view.
interface zapper_flash_sequencer_if;
    logic       frame_start;
    logic       trigger_raw;
    logic       light_sense;
    logic [1:0] flash_mode;
    logic       busy;
    logic       hit;
    logic       miss;
    logic [7:0] shot_count;
    logic [7:0] hit_count;

    modport master (
        output frame_start, trigger_raw, light_sense,
        input  flash_mode, busy, hit, miss, shot_count, hit_count
    );

    modport slave (
        input  frame_start, trigger_raw, light_sense,
        output flash_mode, busy, hit, miss, shot_count, hit_count
    );
endinterface

// File: rtl/zapper_flash_sequencer.sv
// Zapper flash sequencer: debounced trigger, one black frame then WHITE_FRAMES white frames, hit/miss verdict.
// Optional feature macro SHOT_COUNTER_EN enables the 8-bit shot/hit counters (tied to zero otherwise).
module zapper_flash_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int WHITE_FRAMES    = 1,
    parameter int LIGHT_THRESH    = 64,
    parameter int CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    screen_reset,
    zapper_flash_sequencer_if.slave zap
);

    localparam int                DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]        FR_LAST  = 4'(WHITE_FRAMES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  THRESH   = CNT_W'(LIGHT_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_BLACK,
        S_WHITE,
        S_RESULT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        trigSync_q, lightSync_q;
    logic              trig_s, light_s;
    logic [DB_W-1:0]   dbCnt_q;
    logic              trigDb_q, trigDbPrev_q;
    logic              press;
    logic [3:0]        frameCtr_q, frameCtr_d;
    logic [CNT_W-1:0]  darkCnt_q, darkCnt_d;
    logic [CNT_W-1:0]  litCnt_q, litCnt_d;
    logic [1:0]        flashMode_q, flashMode_d;
    logic              hitNow;

    assign trig_s  = trigSync_q[1];
    assign light_s = lightSync_q[1];
    assign press   = trigDb_q & ~trigDbPrev_q;

    // A pending trigger change must persist DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts it.
    always_ff @(posedge clk or posedge screen_reset) begin
        if (screen_reset) begin
            trigSync_q   <= '0;
            lightSync_q  <= '0;
            dbCnt_q      <= '0;
            trigDb_q     <= 1'b0;
            trigDbPrev_q <= 1'b0;
        end else begin
            trigSync_q   <= {trigSync_q[0], zap.trigger_raw};
            lightSync_q  <= {lightSync_q[0], zap.light_sense};
            trigDbPrev_q <= trigDb_q;
            if (trig_s == trigDb_q) begin
                dbCnt_q <= '0;
            end else if (dbCnt_q == DB_LAST) begin
                dbCnt_q  <= '0;
                trigDb_q <= trig_s;
            end else begin
                dbCnt_q <= dbCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge screen_reset) begin
        if (screen_reset) begin
            state_q     <= S_IDLE;
            frameCtr_q  <= '0;
            darkCnt_q   <= '0;
            litCnt_q    <= '0;
            flashMode_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            frameCtr_q  <= frameCtr_d;
            darkCnt_q   <= darkCnt_d;
            litCnt_q    <= litCnt_d;
            flashMode_q <= flashMode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frameCtr_d = frameCtr_q;
        darkCnt_d  = darkCnt_q;
        litCnt_d   = litCnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (press) state_d = S_ARM;
            end
            S_ARM: begin
                darkCnt_d = '0;
                litCnt_d  = '0;
                if (zap.frame_start) state_d = S_BLACK;
            end
            S_BLACK: begin
                if (light_s && darkCnt_q != CNT_MAX) darkCnt_d = darkCnt_q + 1'b1;
                if (zap.frame_start) begin
                    state_d    = S_WHITE;
                    frameCtr_d = '0;
                end
            end
            S_WHITE: begin
                if (light_s && litCnt_q != CNT_MAX) litCnt_d = litCnt_q + 1'b1;
                if (zap.frame_start) begin
                    if (frameCtr_q == FR_LAST) state_d = S_RESULT;
                    else                       frameCtr_d = frameCtr_q + 1'b1;
                end
            end
            S_RESULT: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!trigDb_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Mode follows the state being entered, so the screen switches exactly one cycle after frame_start.
        unique case (state_d)
            S_BLACK: flashMode_d = 2'd1;
            S_WHITE: flashMode_d = 2'd2;
            default: flashMode_d = 2'd0;
        endcase
    end

    assign hitNow         = (state_q == S_RESULT) && (litCnt_q >= THRESH) && (darkCnt_q < THRESH);
    assign zap.hit        = hitNow;
    assign zap.miss       = (state_q == S_RESULT) && !hitNow;
    assign zap.busy       = (state_q != S_IDLE);
    assign zap.flash_mode = flashMode_q;

`ifdef SHOT_COUNTER_EN
    logic [7:0] shotCnt_q, hitCnt_q;

    always_ff @(posedge clk or posedge screen_reset) begin
        if (screen_reset) begin
            shotCnt_q <= 8'd0;
            hitCnt_q  <= 8'd0;
        end else begin
            if (state_q == S_RESULT) shotCnt_q <= shotCnt_q + 8'd1;
            if (hitNow)              hitCnt_q  <= hitCnt_q + 8'd1;
        end
    end

    assign zap.shot_count = shotCnt_q;
    assign zap.hit_count  = hitCnt_q;
`else
    assign zap.shot_count = 8'd0;
    assign zap.hit_count  = 8'd0;
`endif

endmodule
